// File: rtl/apb_master_if.sv
// Command/response handshake and APB bus signals shared by apb_master and its environment.
interface apb_master_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  // Command side
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [STRB_WIDTH-1:0] cmd_strb;

  // Response side
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_slverr;
  logic                  rsp_timeout;

  // APB side
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [STRB_WIDTH-1:0] pstrb;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    input  prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata, pstrb
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    output prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata, pstrb
  );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB master: turns one command into a SETUP/ACCESS transfer
// and reports the result as a one-cycle response pulse, with optional wait timeout.
module apb_master #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic         pclk,
  input  logic         preset,
  apb_master_if.master bus
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  // Wait counter only has to reach TIMEOUT-1; abort fires on the wait cycle after that value.
  localparam int unsigned CNT_WIDTH  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TO_LAST    = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t                state_q;
  logic                  cmd_ready_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [STRB_WIDTH-1:0] pstrb_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_slverr_q;
  logic                  rsp_timeout_q;
  logic [CNT_WIDTH-1:0]  wait_cnt_q;

  logic                  accept_d;
  logic                  timeout_hit_d;

  // Acceptance and timeout qualifiers for the current cycle
  always_comb begin
    accept_d      = bus.cmd_valid && cmd_ready_q;
    timeout_hit_d = (TIMEOUT != 0) && (wait_cnt_q == CNT_WIDTH'(TO_LAST));
  end

  // Transfer FSM with all outputs registered
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q       <= ST_IDLE;
      cmd_ready_q   <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (accept_d) begin
            state_q     <= ST_SETUP;
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b1;
            penable_q   <= 1'b0;
            pwrite_q    <= bus.cmd_write;
            paddr_q     <= bus.cmd_addr;
            pwdata_q    <= bus.cmd_write ? bus.cmd_wdata : '0;
            pstrb_q     <= bus.cmd_write ? bus.cmd_strb : '0;
            wait_cnt_q  <= '0;
          end
        end
        ST_SETUP: begin
          state_q   <= ST_ACCESS;
          penable_q <= 1'b1;
        end
        ST_ACCESS: begin
          if (bus.pready) begin
            state_q       <= ST_IDLE;
            cmd_ready_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= pwrite_q ? '0 : bus.prdata;
            rsp_slverr_q  <= bus.pslverr;
            rsp_timeout_q <= 1'b0;
          end else if (timeout_hit_d) begin
            state_q       <= ST_IDLE;
            cmd_ready_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b1;
            rsp_timeout_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_WIDTH'(1);
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          cmd_ready_q <= 1'b0;
          psel_q      <= 1'b0;
          penable_q   <= 1'b0;
        end
      endcase
    end
  end

  // Drive interface outputs straight from registers
  always_comb begin
    bus.cmd_ready   = cmd_ready_q;
    bus.psel        = psel_q;
    bus.penable     = penable_q;
    bus.pwrite      = pwrite_q;
    bus.paddr       = paddr_q;
    bus.pwdata      = pwdata_q;
    bus.pstrb       = pstrb_q;
    bus.rsp_valid   = rsp_valid_q;
    bus.rsp_rdata   = rsp_rdata_q;
    bus.rsp_slverr  = rsp_slverr_q;
    bus.rsp_timeout = rsp_timeout_q;
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, the address width of cmd_addr and paddr.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the data width (multiple of 8); strobe width is DATA_WIDTH/8.
REQ-003 SHALL have parameter TIMEOUT, default 16, the maximum number of wait cycles in ACCESS; 0 disables the timeout.
REQ-004 SHALL have one clock and an asynchronous, active-high reset.
REQ-005 SHALL have ports:
- pclk  in  1  clock, rising edge
- preset  in  1  asynchronous reset, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  transfer address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_strb  in  DATA_WIDTH/8  write byte strobes
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_slverr  out  1  error flag for the transfer
- rsp_timeout  out  1  transfer aborted by timeout
- psel, penable, pwrite  out  1  APB control signals
- paddr  out  ADDR_WIDTH  APB address
- pwdata  out  DATA_WIDTH  APB write data
- pstrb  out  DATA_WIDTH/8  APB strobes
- prdata  in  DATA_WIDTH  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB error

Function
REQ-006 SHALL implement an FSM with states IDLE, SETUP and ACCESS; all outputs SHALL be registered.
REQ-007 SHALL drive cmd_ready=1 only in IDLE; a command is accepted on a clock edge where cmd_valid && cmd_ready.
REQ-008 On acceptance, SHALL latch cmd_write, cmd_addr, cmd_wdata and cmd_strb, and enter SETUP on the next cycle.
REQ-009 In SETUP, SHALL drive psel=1 and penable=0, with paddr/pwrite/pwdata/pstrb set from the latched command; SHALL enter ACCESS unconditionally after one cycle.
REQ-010 In ACCESS, SHALL drive psel=1 and penable=1; paddr, pwrite, pwdata and pstrb SHALL be held stable until the transfer ends.
REQ-011 SHALL drive pstrb to the latched strobes on writes and to 0 on reads; pwdata SHALL be 0 on reads.
REQ-012 In ACCESS with pready=1, SHALL complete the transfer: capture prdata (reads only, else 0) and pslverr, then return to IDLE.
REQ-013 On completion, SHALL drive psel=0 and penable=0 in the next cycle.
REQ-014 SHALL drive rsp_valid=1 for exactly one cycle, the first IDLE cycle after completion; rsp_rdata, rsp_slverr and rsp_timeout SHALL be held until the next rsp_valid.
REQ-015 Latency: command accepted at edge t; SETUP in cycle t+1; ACCESS in cycle t+2; with zero wait states, rsp_valid=1 and cmd_ready=1 in cycle t+3. Minimum transfer spacing is 3 cycles.
REQ-016 SHALL count cycles spent in ACCESS with pready=0, resetting the count on entry to SETUP.
REQ-017 If TIMEOUT>0 and the count reaches TIMEOUT with pready still 0, SHALL abort: return to IDLE, drive psel=penable=0, and pulse rsp_valid with rsp_timeout=1, rsp_slverr=1 and rsp_rdata=0.
REQ-018 If pready=1 arrives in the same cycle the count reaches TIMEOUT, SHALL treat it as normal completion (rsp_timeout=0).
REQ-019 SHALL ignore pready, pslverr and prdata outside ACCESS.
REQ-020 SHALL ignore changes on cmd_* inputs after acceptance.
REQ-021 SHALL never drive penable=1 without psel=1, and SHALL never drive psel=1 while in IDLE.

Reset
REQ-022 While preset=1, asynchronously and regardless of state, SHALL force state=IDLE, cmd_ready=0 and all other outputs to 0.
REQ-023 SHALL drive cmd_ready=1 in the first cycle after preset deasserts.
REQ-024 Reset mid-transfer SHALL discard the transfer with no rsp_valid issued.

Verification
REQ-025 Zero-wait write: addr 0x10, wdata 0xDEADBEEF, strb 0xF, pready=1 -> SETUP then ACCESS each 1 cycle with pstrb=0xF; rsp_valid at t+3 with rsp_rdata=0, rsp_slverr=0.
REQ-026 Read with 2 wait states: addr 0x04, prdata=0x12345678 when pready rises -> penable high for 3 cycles, paddr stable throughout; rsp_rdata=0x12345678; pstrb=0 throughout.
REQ-027 Error read: addr 0xFF, pslverr=1 with pready -> rsp_slverr=1, rsp_timeout=0.
REQ-028 Timeout: TIMEOUT=4, pready held 0 -> abort after 4 wait cycles; rsp_timeout=1, rsp_slverr=1, psel=0 the next cycle.
REQ-029 Reset mid-ACCESS: preset asserted during wait states -> psel/penable drop to 0 immediately with no rsp_valid; cmd_ready=1 the first cycle after release.
REQ-030 Back-to-back: cmd_valid held high with 3 commands -> 3 transfers spaced exactly 3 cycles apart, with 3 rsp_valid pulses in order.
